// File: rtl/seq_det_pkg.sv
// Shared types, default widths and the configuration check for the serial
// pattern detector controller.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_MAXLEN = 8;
    localparam int DEF_LENW   = 4;
    localparam int DEF_CNTW   = 8;
    localparam int DEF_TOW    = 16;

    // A run needs a length inside 1..maxlen and a non-zero match target.
    function automatic logic cfg_valid(input int len, input int target, input int maxlen);
        return (len != 0) && (len <= maxlen) && (target != 0);
    endfunction

endpackage

// File: rtl/seq_shift_match.sv
// History shift register with a saturating fill counter and a length-masked
// comparator; hit reflects the state the history will have after this shift.
module seq_shift_match
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = DEF_MAXLEN,
    parameter int LENW   = DEF_LENW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift,
    input  logic              din,
    input  logic [LENW-1:0]   len,
    input  logic [MAXLEN-1:0] pattern,
    input  logic              overlap,
    output logic              hit
);

    logic [MAXLEN-1:0] history;
    logic [MAXLEN-1:0] hist_nxt;
    logic [LENW-1:0]   bits_seen;
    logic [LENW-1:0]   bits_nxt;
    logic [MAXLEN-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (LENW'(i) < len);
        end
    end

    assign hist_nxt = {history[MAXLEN-2:0], din};
    assign bits_nxt = (bits_seen == len) ? bits_seen : bits_seen + 1'b1;

    assign hit = shift && (bits_nxt == len) && (((hist_nxt ^ pattern) & mask) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            history   <= '0;
            bits_seen <= '0;
        end else if (clr) begin
            history   <= '0;
            bits_seen <= '0;
        end else if (shift) begin
            history <= hist_nxt;
            // Non-overlapping mode forces a full fresh window before the next hit.
            if (hit && !overlap) begin
                bits_seen <= '0;
            end else begin
                bits_seen <= bits_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Run-time controller for a configurable serial pattern detector: latches a
// one-shot config, counts matches and reports done / timeout / error status.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int MAXLEN = DEF_MAXLEN,
    parameter int LENW   = DEF_LENW,
    parameter int CNTW   = DEF_CNTW,
    parameter int TOW    = DEF_TOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [LENW-1:0]   cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_target,
    input  logic [TOW-1:0]    cfg_timeout,
    input  logic              din,
    input  logic              din_vld,
    output logic              busy,
    output logic              match,
    output logic [CNTW-1:0]   match_cnt,
    output logic              done,
    output logic              timeout,
    output logic              err
);

    state_t            state;
    state_t            state_nxt;
    logic [TOW-1:0]    to_cnt;
    logic [TOW-1:0]    tcnt_nxt;
    logic              busy_nxt;
    logic              match_nxt;
    logic [CNTW-1:0]   cnt_nxt;
    logic [CNTW-1:0]   cnt_inc;
    logic              done_nxt;
    logic              tmo_nxt;
    logic              err_nxt;
    logic              latch_cfg;
    logic              cfg_ok;

    logic [MAXLEN-1:0] pat_q;
    logic [LENW-1:0]   len_q;
    logic              ovl_q;
    logic [CNTW-1:0]   tgt_q;
    logic [TOW-1:0]    tov_q;

    logic              hit;
    logic              clr_hist;
    logic              shift;

    assign cfg_ok   = cfg_valid(32'(cfg_len), 32'(cfg_target), MAXLEN);
    assign cnt_inc  = match_cnt + 1'b1;
    assign clr_hist = (state == ST_ARM);
    assign shift    = (state == ST_RUN) && din_vld;

    seq_shift_match #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW)
    ) u_match (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr_hist),
        .shift   (shift),
        .din     (din),
        .len     (len_q),
        .pattern (pat_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        match_nxt = 1'b0;
        cnt_nxt   = match_cnt;
        done_nxt  = done;
        tmo_nxt   = timeout;
        err_nxt   = err;
        tcnt_nxt  = to_cnt;
        latch_cfg = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_nxt = '0;
                    tmo_nxt = 1'b0;
                    if (!cfg_ok) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_ARM;
                        latch_cfg = 1'b1;
                        busy_nxt  = 1'b1;
                        done_nxt  = 1'b0;
                        err_nxt   = 1'b0;
                    end
                end
            end
            ST_ARM: begin
                tcnt_nxt  = '0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A match on the expiry edge takes priority over the timeout.
                if (hit) begin
                    match_nxt = 1'b1;
                    cnt_nxt   = cnt_inc;
                    tcnt_nxt  = '0;
                    if (cnt_inc == tgt_q) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end else if ((tov_q != '0) && (to_cnt == tov_q - 1'b1)) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    tmo_nxt   = 1'b1;
                end else begin
                    tcnt_nxt = to_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
            match_nxt = 1'b0;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            tmo_nxt   = 1'b0;
            err_nxt   = 1'b0;
            tcnt_nxt  = '0;
            latch_cfg = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            match     <= 1'b0;
            match_cnt <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err       <= 1'b0;
            to_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            busy      <= busy_nxt;
            match     <= match_nxt;
            match_cnt <= cnt_nxt;
            done      <= done_nxt;
            timeout   <= tmo_nxt;
            err       <= err_nxt;
            to_cnt    <= tcnt_nxt;
        end
    end

    // Configuration is pure data: only captured on an accepted start.
    always_ff @(posedge clk) begin
        if (latch_cfg) begin
            pat_q <= cfg_pattern;
            len_q <= cfg_len;
            ovl_q <= cfg_overlap;
            tgt_q <= cfg_target;
            tov_q <= cfg_timeout;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_seq_det_ctrl;

    localparam int MAXLEN = 8;
    localparam int LENW   = 4;
    localparam int CNTW   = 8;
    localparam int TOW    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LENW-1:0]   cfg_len;
    logic              cfg_overlap;
    logic [CNTW-1:0]   cfg_target;
    logic [TOW-1:0]    cfg_timeout;
    logic              din;
    logic              din_vld;
    logic              busy;
    logic              match;
    logic [CNTW-1:0]   match_cnt;
    logic              done;
    logic              timeout;
    logic              err;

    always #5 clk = ~clk;

    seq_det_ctrl #(
        .MAXLEN (MAXLEN),
        .LENW   (LENW),
        .CNTW   (CNTW),
        .TOW    (TOW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_target  (cfg_target),
        .cfg_timeout (cfg_timeout),
        .din         (din),
        .din_vld     (din_vld),
        .busy        (busy),
        .match       (match),
        .match_cnt   (match_cnt),
        .done        (done),
        .timeout     (timeout),
        .err         (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 idle, 1 arm, 2 run, 3 done.
    int       m_phase;
    bit       m_busy, m_match, m_done, m_to, m_err;
    int       m_cnt;
    int       m_idle;
    bit       win[$];
    logic [7:0] l_pat;
    int       l_len, l_tgt, l_tov;
    bit       l_ovl;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_busy  = 0;
        m_match = 0;
        m_done  = 0;
        m_to    = 0;
        m_err   = 0;
        m_cnt   = 0;
        m_idle  = 0;
        win.delete();
    endtask

    task automatic model_step();
        bit hitm;
        int cl, ct;
        if (abort) begin
            model_reset();
            return;
        end
        m_match = 0;
        case (m_phase)
            0, 3: begin
                if (start) begin
                    cl = int'(cfg_len);
                    ct = int'(cfg_target);
                    m_cnt = 0;
                    m_to  = 0;
                    if (cl == 0 || cl > MAXLEN || ct == 0) begin
                        m_phase = 3; m_done = 1; m_err = 1; m_busy = 0;
                    end else begin
                        l_pat = cfg_pattern; l_len = cl; l_ovl = cfg_overlap;
                        l_tgt = ct; l_tov = int'(cfg_timeout);
                        m_phase = 1; m_busy = 1; m_done = 0; m_err = 0;
                    end
                end
            end
            1: begin
                win.delete();
                m_idle  = 0;
                m_phase = 2;
            end
            default: begin
                hitm = 0;
                if (din_vld) begin
                    win.push_back(din);
                    if (win.size() > l_len) void'(win.pop_front());
                    if (win.size() == l_len) begin
                        hitm = 1;
                        for (int i = 0; i < l_len; i++)
                            if (win[i] != l_pat[l_len-1-i]) hitm = 0;
                    end
                end
                if (hitm) begin
                    m_match = 1;
                    m_cnt++;
                    m_idle = 0;
                    if (!l_ovl) win.delete();
                    if (m_cnt == l_tgt) begin
                        m_phase = 3; m_done = 1; m_busy = 0;
                    end
                end else if (l_tov != 0 && m_idle + 1 == l_tov) begin
                    m_phase = 3; m_done = 1; m_to = 1; m_busy = 0;
                end else begin
                    m_idle++;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check_val("busy",      32'(busy),      32'(m_busy));
        check_val("match",     32'(match),     32'(m_match));
        check_val("match_cnt", 32'(match_cnt), m_cnt);
        check_val("done",      32'(done),      32'(m_done));
        check_val("timeout",   32'(timeout),   32'(m_to));
        check_val("err",       32'(err),       32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic feed(input bit b, input bit v);
        din     = b;
        din_vld = v;
        step();
    endtask

    task automatic start_run(input logic [7:0] p, input logic [3:0] l, input logic o,
                             input logic [7:0] t, input logic [15:0] tov);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t; cfg_timeout = tov;
        start = 1'b1;
        din_vld = 1'b0;
        step();
        start = 1'b0;
        step();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        s = 8'b1010_1010;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0; cfg_timeout = '0;
        din = 1'b0; din_vld = 1'b0;
        model_reset();
        #3;
        check_outputs();
        rst = 1'b1;
        step();

        // Non-overlapping 1010
        start_run(8'b1010, 4'd4, 1'b0, 8'd2, 16'd0);
        for (int i = 7; i >= 0; i--) feed(s[i], 1'b1);
        check_val("nonovl_done", 32'(done), 32'd1);
        check_val("nonovl_cnt", 32'(match_cnt), 32'd2);
        do_abort();

        // Overlapping 1010
        start_run(8'b1010, 4'd4, 1'b1, 8'd3, 16'd0);
        for (int i = 7; i >= 0; i--) feed(s[i], 1'b1);
        check_val("ovl_done", 32'(done), 32'd1);
        check_val("ovl_cnt", 32'(match_cnt), 32'd3);
        do_abort();

        // Gaps carry the opposite bit, which must not be sampled
        start_run(8'b1010, 4'd4, 1'b0, 8'd2, 16'd0);
        for (int i = 3; i >= 0; i--) begin
            feed(s[i], 1'b1);
            feed(~s[i], 1'b0);
        end
        check_val("gap_cnt", 32'(match_cnt), 32'd1);
        check_val("gap_busy", 32'(busy), 32'd1);
        do_abort();

        // Timeout expiry
        start_run(8'b1010, 4'd4, 1'b0, 8'd1, 16'd5);
        for (int i = 0; i < 5; i++) feed(1'b0, 1'b1);
        check_val("tmo_flag", 32'(timeout), 32'd1);
        check_val("tmo_done", 32'(done), 32'd1);
        do_abort();

        // Match on the expiry edge wins
        start_run(8'b0001, 4'd4, 1'b0, 8'd1, 16'd5);
        for (int i = 0; i < 4; i++) feed(1'b0, 1'b1);
        feed(1'b1, 1'b1);
        check_val("race_tmo", 32'(timeout), 32'd0);
        check_val("race_cnt", 32'(match_cnt), 32'd1);
        do_abort();

        // Invalid configurations
        cfg_pattern = 8'b1010; cfg_len = 4'd0; cfg_target = 8'd2; cfg_timeout = '0;
        start = 1'b1;
        step();
        check_val("inv_len_err", 32'(err), 32'd1);
        cfg_len = 4'd4; cfg_target = 8'd0;
        step();
        check_val("inv_tgt_err", 32'(err), 32'd1);
        start = 1'b0;
        step();
        do_abort();

        // Abort after one match
        start_run(8'b1010, 4'd4, 1'b0, 8'd3, 16'd0);
        for (int i = 3; i >= 0; i--) feed(s[i], 1'b1);
        feed(1'b1, 1'b1);
        do_abort();
        check_val("abort_cnt", 32'(match_cnt), 32'd0);

        // Start while busy must leave the running config alone
        start_run(8'b1010, 4'd4, 1'b1, 8'd2, 16'd0);
        feed(1'b1, 1'b1);
        cfg_pattern = 8'b01; cfg_len = 4'd2; cfg_overlap = 1'b0; cfg_target = 8'd1;
        start = 1'b1;
        feed(1'b0, 1'b1);
        start = 1'b0;
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b1);
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b1);
        check_val("busy_start_cnt", 32'(match_cnt), 32'd2);
        do_abort();

        // Asynchronous reset mid-run
        start_run(8'b1010, 4'd4, 1'b1, 8'd5, 16'd0);
        for (int i = 3; i >= 0; i--) feed(s[i], 1'b1);
        feed(1'b1, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        rst = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            abort       = ($urandom % 100) == 0;
            start       = ($urandom % 20) == 0;
            cfg_pattern = 8'($urandom);
            cfg_len     = 4'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom);
            cfg_target  = (($urandom % 16) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            cfg_timeout = (($urandom % 3) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            din         = 1'($urandom);
            din_vld     = ($urandom % 4) != 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Run-time controller for a serial pattern detector, generalising the fixed 1010 Moore detectors.
- Accepts a one-shot configuration (pattern, length, overlap mode, match target, timeout) on start, then watches a qualified serial bit stream.
- Counts matches and reports done, timeout or error status to the host.
- Sits between a host/config interface and the serial data source.

Parameters:
- MAXLEN, 8, maximum pattern length in bits.
- LENW, 4, width of cfg_len; must satisfy 2**LENW > MAXLEN.
- CNTW, 8, width of the match target and match counter.
- TOW, 16, width of the timeout configuration and timeout counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to latch cfg_* and begin a run.
- abort  in  1  forces return to IDLE from any state.
- cfg_pattern  in  MAXLEN  pattern; bit cfg_len-1 is the first bit received.
- cfg_len  in  LENW  pattern length, valid range 1..MAXLEN.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  in  CNTW  number of matches to finish; 0 is invalid.
- cfg_timeout  in  TOW  idle cycles allowed between matches; 0 disables timeout.
- din  in  1  serial data bit.
- din_vld  in  1  din is sampled only when this is high.
- busy  out  1  high in ARM and RUN.
- match  out  1  one-cycle pulse per detected pattern.
- match_cnt  out  CNTW  matches in the current run.
- done  out  1  level; high in DONE.
- timeout  out  1  level; run ended by timeout (valid while done).
- err  out  1  level; run rejected for invalid config (valid while done).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, match, done, timeout and err = 0. match_cnt, history, bits_seen and timeout counter = 0.
- States: IDLE, ARM, RUN, DONE. All outputs are registered.
- IDLE/DONE with start=1:
  - If the config is invalid (cfg_len==0, cfg_len>MAXLEN, or cfg_target==0): go to DONE with err=1 and match_cnt=0.
  - Otherwise: latch all cfg_* inputs, clear match_cnt, timeout, err and done, and go to ARM.
- start while busy is ignored.
- ARM lasts exactly one cycle: clears history, bits_seen and the timeout counter, then goes to RUN. din is ignored in ARM.
- RUN, when din_vld=1:
  - history <= {history[MAXLEN-2:0], din}.
  - bits_seen increments, saturating at the latched length.
- Match condition: the updated bits_seen == len and the updated history[len-1:0] == pattern[len-1:0].
  - match pulses high for the cycle after the sampling edge.
  - match_cnt increments on the same edge.
- After a match:
  - overlap=0: bits_seen is cleared, so the next match needs len fresh bits.
  - overlap=1: bits_seen is retained, so the suffix can be reused.
- Target reached: when match_cnt reaches the target, go to DONE on that same edge (done=1, busy=0). Any further din is ignored.
- Timeout counter:
  - Active in RUN only; increments every clock (regardless of din_vld) and clears on each match.
  - When timeout is enabled and the counter reaches timeout-1 without a match on that edge, go to DONE with timeout=1.
  - If a match and timeout expiry occur on the same edge, the match wins: count is updated and the counter is cleared.
- DONE holds done, match_cnt, timeout and err until the next start or abort.
- abort=1 returns to IDLE from any state and clears every output and counter. abort wins over a simultaneous start.
- match_cnt does not wrap: DONE is always entered at target, and target is at most 2**CNTW-1.
- No combinational path from any input to any output.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE, ARM, RUN, DONE);
  - the defaults for MAXLEN, LENW, CNTW and TOW;
  - the config-validity function.
- Sub-module seq_shift_match holds the history shift register, the saturating bits_seen counter, the length-masked comparator and overlap clearing.
  - Its inputs are clr, shift, din, len, pattern and overlap.
  - Its output is a combinational hit.
- The top level holds the FSM, the match and timeout counters, and the status registers.

Test Plan:
- Non-overlap: pattern=1010, len=4, overlap=0, target=2, timeout=0. Stream 1,0,1,0,1,0,1,0 with din_vld always 1 → match after bits 4 and 8; match_cnt=2, done=1, timeout=0.
- Overlap: same stream with overlap=1, target=3 → matches after bits 4, 6 and 8; done after bit 8 with match_cnt=3.
- din_vld gaps: stream 1,0,1,0 with din_vld=0 on alternate cycles → exactly one match, and no bit is sampled during the gaps.
- Timeout: timeout=5, target=1, stream all 0 → done=1, timeout=1, match_cnt=0 exactly 5 cycles after RUN entry. Also drive the completing bit on the expiry edge → match wins, timeout=0.
- Invalid config: start with cfg_len=0, then with cfg_target=0 → DONE next cycle with err=1, busy never asserted.
- Abort and reset: abort mid-RUN after one match → IDLE, match_cnt=0. Assert rst low asynchronously mid-RUN → all outputs 0 immediately. start while busy → ignored, config unchanged.
